// File: rtl/hazard_sched_ctrl.sv
// Hazard scheduler beside the ID stage: load-use and HI/LO stalls, branch flush,
// and sequencing of the shared multi-cycle multiply/divide unit.
module hazard_sched_ctrl #(
    parameter int MD_LATENCY = 32,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_md,
    input  logic             id_is_mfhilo,
    input  logic             ex_mem_read,
    input  logic [4:0]       ex_rt,
    input  logic             ex_branch_tkn,
    output logic             pc_en,
    output logic             ifid_en,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             md_start,
    output logic             md_busy,
    output logic             md_done,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam int CTR_W = (MD_LATENCY > 1) ? $clog2(MD_LATENCY) : 1;
    localparam logic [CTR_W-1:0] CTR_LOAD = CTR_W'(MD_LATENCY - 1);

    typedef enum logic {
        S_RUN,
        S_MD_BUSY
    } state_t;

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   md_ctr_q, md_ctr_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic load_use;
    logic md_haz;
    logic stall;
    logic launch;

    always_comb begin
        load_use = ex_mem_read && (ex_rt != 5'd0) && id_valid &&
                   ((id_use_rs && (id_rs == ex_rt)) || (id_use_rt && (id_rt == ex_rt)));
        md_haz   = (state_q == S_MD_BUSY) && id_valid && (id_is_md || id_is_mfhilo);
        // A taken branch squashes the ID instruction, so it outranks both stalls.
        stall    = !ex_branch_tkn && (load_use || md_haz);
        launch   = !ex_branch_tkn && !stall && (state_q == S_RUN) && id_valid && id_is_md;
    end

    // NOTE: every output is forced low while rst_n is asserted, so the reset
    // level is folded into this combinational block rather than only the flops.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        md_start    = 1'b0;
        md_busy     = 1'b0;
        md_done     = 1'b0;
        if (rst_n) begin
            if (ex_branch_tkn) begin
                pc_en       = 1'b1;
                ifid_en     = 1'b1;
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
            end else if (stall) begin
                idex_bubble = 1'b1;
            end else begin
                pc_en   = 1'b1;
                ifid_en = 1'b1;
            end
            md_start = launch;
            md_busy  = (state_q == S_MD_BUSY);
            md_done  = (state_q == S_MD_BUSY) && (md_ctr_q == '0);
        end
    end
    assign stall_cnt = stall_cnt_q;

    always_comb begin
        state_d     = state_q;
        md_ctr_d    = md_ctr_q;
        stall_cnt_d = stall_cnt_q;
        case (state_q)
            S_RUN: begin
                if (launch) begin
                    state_d  = S_MD_BUSY;
                    md_ctr_d = CTR_LOAD;
                end
            end
            S_MD_BUSY: begin
                // The unit always runs to completion; a flush never aborts it.
                if (md_ctr_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    md_ctr_d = md_ctr_q - CTR_W'(1);
                end
            end
            default: state_d = S_RUN;
        endcase
        if (stall && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_RUN;
            md_ctr_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            md_ctr_q    <= md_ctr_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

endmodule

// File: tb/tb_hazard_sched_ctrl.sv
// Self-checking bench for hazard_sched_ctrl: directed scenarios plus random
// stimulus compared against a cycle-level behavioural model.
module tb_hazard_sched_ctrl;

    localparam int MD_LAT = 4;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic clk = 1'b0;
    logic rst_n;
    logic id_valid, id_use_rs, id_use_rt, id_is_md, id_is_mfhilo;
    logic [4:0] id_rs, id_rt, ex_rt;
    logic ex_mem_read, ex_branch_tkn;
    logic pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy, md_done;
    logic [CNT_W-1:0] stall_cnt;

    int checks = 0;
    int failures = 0;

    // Model state: cycles of unit activity still to come, and stall count.
    int m_rem = 0;
    int m_cnt = 0;
    logic e_pc_en, e_ifid_en, e_flush, e_bubble, e_start, e_busy, e_done;
    logic e_lu, e_mdh;

    hazard_sched_ctrl #(.MD_LATENCY(MD_LAT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
        .id_is_md(id_is_md), .id_is_mfhilo(id_is_mfhilo),
        .ex_mem_read(ex_mem_read), .ex_rt(ex_rt), .ex_branch_tkn(ex_branch_tkn),
        .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .md_start(md_start), .md_busy(md_busy),
        .md_done(md_done), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_eval();
        logic hit_rs, hit_rt;
        hit_rs = id_use_rs && (id_rs == ex_rt);
        hit_rt = id_use_rt && (id_rt == ex_rt);
        e_lu   = ex_mem_read && (ex_rt != 0) && id_valid && (hit_rs || hit_rt);
        e_mdh  = (m_rem > 0) && id_valid && (id_is_md || id_is_mfhilo);
        e_flush  = ex_branch_tkn;
        e_bubble = ex_branch_tkn || e_lu || e_mdh;
        e_pc_en  = ex_branch_tkn || !(e_lu || e_mdh);
        e_ifid_en = e_pc_en;
        e_start  = !ex_branch_tkn && !e_lu && !e_mdh && (m_rem == 0) && id_valid && id_is_md;
        e_busy   = (m_rem > 0);
        e_done   = (m_rem == 1);
        if (!rst_n) begin
            {e_pc_en, e_ifid_en, e_flush, e_bubble, e_start, e_busy, e_done} = '0;
        end
    endtask

    task automatic tick();
        model_eval();
        @(posedge clk);
        if (rst_n) begin
            if (!e_flush && (e_lu || e_mdh)) m_cnt = (m_cnt >= CNT_MAX) ? CNT_MAX : m_cnt + 1;
            if (e_start) m_rem = MD_LAT;
            else if (m_rem > 0) m_rem = m_rem - 1;
        end else begin
            m_rem = 0;
            m_cnt = 0;
        end
        #1;
    endtask

    task automatic idle_inputs();
        id_valid = 0; id_rs = 0; id_rt = 0; id_use_rs = 0; id_use_rt = 0;
        id_is_md = 0; id_is_mfhilo = 0; ex_mem_read = 0; ex_rt = 0; ex_branch_tkn = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        m_rem = 0;
        m_cnt = 0;
        tick();
        tick();
        rst_n = 1;
        tick();
    endtask

    task automatic test_reset();
        idle_inputs();
        id_valid = 1; id_is_md = 1;
        rst_n = 0;
        m_rem = 0; m_cnt = 0;
        #2;
        checks++;
        if ({pc_en, ifid_en, md_start, md_busy, md_done, ifid_flush, idex_bubble} !== 7'b0) begin
            failures++;
            $display("FAIL reset_outputs: got %b expected 0000000",
                     {pc_en, ifid_en, md_start, md_busy, md_done, ifid_flush, idex_bubble});
        end
        checks++;
        if (stall_cnt !== 0) begin
            failures++;
            $display("FAIL reset_stall_cnt: got %0d expected 0", stall_cnt);
        end
        tick();
        idle_inputs();
        rst_n = 1;
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b1 || ifid_en !== 1'b1 || idex_bubble !== 1'b0) begin
            failures++;
            $display("FAIL reset_release_normal: pc_en=%b ifid_en=%b bubble=%b expected 1 1 0",
                     pc_en, ifid_en, idex_bubble);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        idle_inputs();
        ex_mem_read = 1; ex_rt = 5'd8; id_valid = 1; id_rs = 5'd8; id_use_rs = 1;
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b0 || ifid_en !== 1'b0 || idex_bubble !== 1'b1 || ifid_flush !== 1'b0) begin
            failures++;
            $display("FAIL load_use_stall: pc_en=%b ifid_en=%b bubble=%b flush=%b expected 0 0 1 0",
                     pc_en, ifid_en, idex_bubble, ifid_flush);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 1 || pc_en !== 1'b1) begin
            failures++;
            $display("FAIL load_use_count: stall_cnt=%0d pc_en=%b expected 1 1", stall_cnt, pc_en);
        end
        ex_mem_read = 1; ex_rt = 5'd0; id_valid = 1; id_rt = 5'd0; id_use_rt = 1;
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b1 || idex_bubble !== 1'b0) begin
            failures++;
            $display("FAIL load_use_r0: pc_en=%b bubble=%b expected 1 0", pc_en, idex_bubble);
        end
        tick();
        ex_rt = 5'd9; id_rt = 5'd9; id_use_rt = 1; id_rs = 5'd9; id_use_rs = 0;
        @(negedge clk);
        checks++;
        if (pc_en !== 1'b0 || idex_bubble !== 1'b1) begin
            failures++;
            $display("FAIL load_use_rt: pc_en=%b bubble=%b expected 0 1", pc_en, idex_bubble);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 2) begin
            failures++;
            $display("FAIL load_use_r0_count: stall_cnt=%0d expected 2", stall_cnt);
        end
    endtask

    task automatic test_priority();
        do_reset();
        ex_mem_read = 1; ex_rt = 5'd8; id_valid = 1; id_rs = 5'd8; id_use_rs = 1;
        ex_branch_tkn = 1;
        @(negedge clk);
        checks++;
        if (ifid_flush !== 1'b1 || pc_en !== 1'b1 || ifid_en !== 1'b1 || idex_bubble !== 1'b1) begin
            failures++;
            $display("FAIL priority_flush: flush=%b pc_en=%b ifid_en=%b bubble=%b expected 1 1 1 1",
                     ifid_flush, pc_en, ifid_en, idex_bubble);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 0) begin
            failures++;
            $display("FAIL priority_count: stall_cnt=%0d expected 0", stall_cnt);
        end
    endtask

    task automatic test_mult_mflo();
        int busy_n, stall_n, done_at, rel_at, start_n;
        do_reset();
        id_valid = 1; id_is_md = 1;
        @(negedge clk);
        checks++;
        if (md_start !== 1'b1 || md_busy !== 1'b0) begin
            failures++;
            $display("FAIL mult_start: md_start=%b md_busy=%b expected 1 0", md_start, md_busy);
        end
        tick();
        id_is_md = 0; id_is_mfhilo = 1;
        busy_n = 0; stall_n = 0; done_at = -1; rel_at = -1; start_n = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (md_busy) busy_n++;
            if (!pc_en) stall_n++;
            if (md_start) start_n++;
            if (md_done) done_at = i;
            if (pc_en) begin
                rel_at = i;
                break;
            end
            tick();
        end
        checks++;
        if (busy_n !== MD_LAT || stall_n !== 4 || done_at !== 3 || rel_at !== 4 || start_n !== 0) begin
            failures++;
            $display("FAIL mult_mflo_seq: busy=%0d stall=%0d done_at=%0d release_at=%0d starts=%0d expected 4 4 3 4 0",
                     busy_n, stall_n, done_at, rel_at, start_n);
        end
        checks++;
        if (stall_cnt !== 4) begin
            failures++;
            $display("FAIL mult_mflo_count: stall_cnt=%0d expected 4", stall_cnt);
        end
        tick();
        idle_inputs();
    endtask

    task automatic test_branch_in_busy();
        do_reset();
        id_valid = 1; id_is_md = 1;
        tick();
        idle_inputs();
        tick();
        id_valid = 1; id_is_md = 1; ex_branch_tkn = 1;
        @(negedge clk);
        checks++;
        if (ifid_flush !== 1'b1 || pc_en !== 1'b1 || md_start !== 1'b0 || md_busy !== 1'b1 || md_done !== 1'b0) begin
            failures++;
            $display("FAIL branch_busy_flush: flush=%b pc_en=%b start=%b busy=%b done=%b expected 1 1 0 1 0",
                     ifid_flush, pc_en, md_start, md_busy, md_done);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (md_done !== 1'b0 || md_busy !== 1'b1) begin
            failures++;
            $display("FAIL branch_busy_third: done=%b busy=%b expected 0 1", md_done, md_busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if (md_done !== 1'b1 || md_busy !== 1'b1) begin
            failures++;
            $display("FAIL branch_busy_done: done=%b busy=%b expected 1 1", md_done, md_busy);
        end
        tick();
        id_valid = 1; id_is_md = 1; ex_branch_tkn = 1;
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b0 || md_start !== 1'b0 || ifid_flush !== 1'b1 || stall_cnt !== 0) begin
            failures++;
            $display("FAIL branch_div_run: busy=%b start=%b flush=%b stall_cnt=%0d expected 0 0 1 0",
                     md_busy, md_start, ifid_flush, stall_cnt);
        end
        tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (md_busy !== 1'b0) begin
            failures++;
            $display("FAIL branch_div_nolaunch: busy=%b expected 0", md_busy);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        ex_mem_read = 1; ex_rt = 5'd3; id_valid = 1; id_rs = 5'd3; id_use_rs = 1;
        for (int i = 0; i < 20; i++) tick();
        idle_inputs();
        @(negedge clk);
        checks++;
        if (stall_cnt !== 4'd15) begin
            failures++;
            $display("FAIL saturation: stall_cnt=%0d expected 15", stall_cnt);
        end
    endtask

    task automatic test_reset_mid_op();
        int bad;
        do_reset();
        id_valid = 1; id_is_md = 1;
        tick();
        idle_inputs();
        tick();
        rst_n = 0;
        m_rem = 0; m_cnt = 0;
        #1;
        checks++;
        if (md_busy !== 1'b0 || md_done !== 1'b0 || pc_en !== 1'b0 || ifid_en !== 1'b0 || stall_cnt !== 0) begin
            failures++;
            $display("FAIL reset_mid_op: busy=%b done=%b pc_en=%b ifid_en=%b cnt=%0d expected 0 0 0 0 0",
                     md_busy, md_done, pc_en, ifid_en, stall_cnt);
        end
        tick();
        rst_n = 1;
        bad = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (md_done !== 1'b0 || md_busy !== 1'b0) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin
            failures++;
            $display("FAIL reset_no_done: %0d cycles showed busy/done, expected 0", bad);
        end
    endtask

    task automatic test_random();
        logic [6:0] got, exp;
        int bad;
        do_reset();
        bad = 0;
        for (int i = 0; i < 400; i++) begin
            id_valid      = ($urandom_range(0, 7) != 0);
            id_rs         = 5'($urandom_range(0, 3));
            id_rt         = 5'($urandom_range(0, 3));
            id_use_rs     = 1'($urandom);
            id_use_rt     = 1'($urandom);
            id_is_md      = ($urandom_range(0, 3) == 0);
            id_is_mfhilo  = ($urandom_range(0, 3) == 0);
            ex_mem_read   = ($urandom_range(0, 2) == 0);
            ex_rt         = 5'($urandom_range(0, 3));
            ex_branch_tkn = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            model_eval();
            got = {pc_en, ifid_en, ifid_flush, idex_bubble, md_start, md_busy, md_done};
            exp = {e_pc_en, e_ifid_en, e_flush, e_bubble, e_start, e_busy, e_done};
            checks++;
            if (got !== exp || stall_cnt !== CNT_W'(m_cnt)) begin
                failures++;
                bad++;
                if (bad < 5)
                    $display("FAIL random_cycle_%0d: outputs=%b cnt=%0d expected %b cnt=%0d",
                             i, got, stall_cnt, exp, m_cnt);
            end
            tick();
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        rst_n = 0;
        test_reset();
        test_load_use();
        test_priority();
        test_mult_mflo();
        test_branch_in_busy();
        test_saturation();
        test_reset_mid_op();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
